// File: rtl/pattern_pkg.sv
// Shared types and colour helpers for the pattern_gen test-pattern generator.
// Holds the mode enumeration, the RGB struct, the 8-entry colour code table
// and the function that expands a 3-bit code into full-scale components.
package pattern_pkg;

  typedef enum logic [1:0] {
    HBARS   = 2'd0,
    VBARS   = 2'd1,
    CHECKER = 2'd2,
    SCROLL  = 2'd3
  } pattern_mode_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Code bit 2 = red, bit 1 = green, bit 0 = blue. Entry 7 is listed first.
  localparam logic [7:0][2:0] COLOUR_TABLE = {
    3'b000,  // 7 none
    3'b111,  // 6 R+G+B
    3'b011,  // 5 G+B
    3'b101,  // 4 R+B
    3'b110,  // 3 R+G
    3'b001,  // 2 B
    3'b010,  // 1 G
    3'b100   // 0 R
  };

  localparam rgb_t RGB_BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};
  localparam rgb_t RGB_WHITE = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};

  // Expand a 3-bit colour code into 0/255 components.
  function automatic rgb_t code_to_rgb(input logic [2:0] code);
    rgb_t c;
    c.r = {8{code[2]}};
    c.g = {8{code[1]}};
    c.b = {8{code[0]}};
    return c;
  endfunction

endpackage

// File: rtl/pattern_gen_bar_index.sv
// bar_index: combinational compare ladder returning the largest bar number i
// (0..N_BARS-1) whose left/top edge (EXTENT*i)/N_BARS is <= coord_i.
// Thresholds are elaboration-time constants, so the ladder is plain compares.
module bar_index #(
  parameter int EXTENT = 800,
  parameter int N_BARS = 6,
  parameter int CW     = 11
) (
  input  logic [CW-1:0] coord_i,
  output logic [2:0]    idx_o
);

  // Walk the increasing thresholds; the last one passed wins.
  always_comb begin
    idx_o = 3'd0;
    for (int i = 1; i < N_BARS; i++) begin
      if (32'(coord_i) >= 32'((EXTENT * i) / N_BARS)) begin
        idx_o = 3'(i);
      end else begin
        idx_o = idx_o;
      end
    end
  end

endmodule

// File: rtl/pattern_gen.sv
// pattern_gen: run-time selectable test-pattern generator (horizontal bars,
// vertical bars, checkerboard, horizontally scrolling bars) with one clock of
// latency from spot position to registered colour.
// Optional build macro PATTERN_BORDER_EN adds a 1-pixel white frame border.
module pattern_gen
  import pattern_pkg::*;
#(
  parameter int HACTIVE     = 800,
  parameter int VACTIVE     = 600,
  parameter int N_BARS      = 6,
  parameter int CELL_LOG2   = 6,
  parameter int SCROLL_STEP = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic signed [10:0] spotX,
  input  logic signed [10:0] spotY,
  input  logic               enable,
  input  logic [1:0]         mode_sel,
  output logic [7:0]         bck_r,
  output logic [7:0]         bck_g,
  output logic [7:0]         bck_b,
  output logic               frame_tick
);

  localparam int OFS_W = $clog2(HACTIVE);
  localparam logic [OFS_W-1:0] STEP_V  = OFS_W'(SCROLL_STEP);
  localparam logic [OFS_W-1:0] WRAP_AT = OFS_W'(HACTIVE - SCROLL_STEP);

  pattern_mode_t    mode_q, mode_d;
  logic [OFS_W-1:0] offset_q, offset_d;
  rgb_t             rgb_q, rgb_d;
  logic             frame_tick_q;

  logic        sof_s;
  logic        active_s;
  logic [10:0] x_s, y_s;
  logic [11:0] p_sum_s, p_wrap_s, x_coord_s;
  logic [11:0] cell_sum_s;
  logic [2:0]  y_idx_s, x_idx_s, chk_idx_s, idx_s;
  rgb_t        pix_rgb_s;

  // Spot position qualification: the sign bits gate off negative values so
  // only non-negative, in-range coordinates reach the unsigned pattern path.
  always_comb begin
    x_s      = spotX;
    y_s      = spotY;
    sof_s    = (spotX == 11'sd0) && (spotY == 11'sd0);
    active_s = !spotX[10] && !spotY[10] &&
               (x_s < 11'(HACTIVE)) && (y_s < 11'(VACTIVE));
  end

  // Mode loads only at start-of-frame; the loaded value already drives (0,0).
  always_comb begin
    if (sof_s) begin
      mode_d = pattern_mode_t'(mode_sel);
    end else begin
      mode_d = mode_q;
    end
  end

  // Scroll offset advances at SOF in SCROLL with enable high, modulo HACTIVE.
  always_comb begin
    offset_d = offset_q;
    if (sof_s && (mode_d == SCROLL) && enable) begin
      if (offset_q >= WRAP_AT) begin
        offset_d = offset_q - WRAP_AT;
      end else begin
        offset_d = offset_q + STEP_V;
      end
    end else begin
      offset_d = offset_q;
    end
  end

  // Scrolled column p = x + offset folded back into 0..HACTIVE-1, plus the
  // checkerboard cell sum; the next offset is used so a bump shows at (0,0).
  always_comb begin
    p_sum_s = 12'(x_s) + 12'(offset_d);
    if (p_sum_s >= 12'(HACTIVE)) begin
      p_wrap_s = p_sum_s - 12'(HACTIVE);
    end else begin
      p_wrap_s = p_sum_s;
    end
    if (mode_d == SCROLL) begin
      x_coord_s = p_wrap_s;
    end else begin
      x_coord_s = 12'(x_s);
    end
    cell_sum_s = 12'(x_s >> CELL_LOG2) + 12'(y_s >> CELL_LOG2);
    chk_idx_s  = 3'(cell_sum_s % 12'(N_BARS));
  end

  bar_index #(
    .EXTENT(VACTIVE),
    .N_BARS(N_BARS),
    .CW    (11)
  ) u_bar_y (
    .coord_i(y_s),
    .idx_o  (y_idx_s)
  );

  // Shared between VBARS (raw column) and SCROLL (folded column).
  bar_index #(
    .EXTENT(HACTIVE),
    .N_BARS(N_BARS),
    .CW    (12)
  ) u_bar_x (
    .coord_i(x_coord_s),
    .idx_o  (x_idx_s)
  );

  // Pick the colour index for the effective mode.
  always_comb begin
    case (mode_d)
      HBARS:   idx_s = y_idx_s;
      VBARS:   idx_s = x_idx_s;
      CHECKER: idx_s = chk_idx_s;
      SCROLL:  idx_s = x_idx_s;
      default: idx_s = y_idx_s;
    endcase
    pix_rgb_s = code_to_rgb(COLOUR_TABLE[idx_s]);
  end

`ifdef PATTERN_BORDER_EN
  logic edge_s;
  // Outermost rows/columns of the active region form the border.
  always_comb begin
    edge_s = (x_s == 11'd0) || (x_s == 11'(HACTIVE - 1)) ||
             (y_s == 11'd0) || (y_s == 11'(VACTIVE - 1));
  end
`endif

  // Final colour: black outside the active area or when disabled.
  always_comb begin
    rgb_d = RGB_BLACK;
    if (enable && active_s) begin
`ifdef PATTERN_BORDER_EN
      if (edge_s) begin
        rgb_d = RGB_WHITE;
      end else begin
        rgb_d = pix_rgb_s;
      end
`else
      rgb_d = pix_rgb_s;
`endif
    end else begin
      rgb_d = RGB_BLACK;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q       <= HBARS;
      offset_q     <= '0;
      rgb_q        <= RGB_BLACK;
      frame_tick_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      offset_q     <= offset_d;
      rgb_q        <= rgb_d;
      frame_tick_q <= sof_s;
    end
  end

  assign bck_r      = rgb_q.r;
  assign bck_g      = rgb_q.g;
  assign bck_b      = rgb_q.b;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Self-checking bench for pattern_gen: a behavioural model derived from the
// pattern rules predicts every output cycle, plus fixed literal expectations.
module tb_pattern_gen;

  localparam int HACTIVE     = 800;
  localparam int VACTIVE     = 600;
  localparam int N_BARS      = 6;
  localparam int CELL_LOG2   = 6;
  localparam int SCROLL_STEP = 2;

  logic               clk = 1'b0;
  logic               reset_n;
  logic signed [10:0] spot_x, spot_y;
  logic               enable;
  logic [1:0]         mode_sel;
  logic [7:0]         bck_r, bck_g, bck_b;
  logic               frame_tick;

  int n_cmp = 0;
  int n_bad = 0;
  int m_mode = 0;
  int m_off  = 0;

  pattern_gen #(
    .HACTIVE    (HACTIVE),
    .VACTIVE    (VACTIVE),
    .N_BARS     (N_BARS),
    .CELL_LOG2  (CELL_LOG2),
    .SCROLL_STEP(SCROLL_STEP)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .spotX     (spot_x),
    .spotY     (spot_y),
    .enable    (enable),
    .mode_sel  (mode_sel),
    .bck_r     (bck_r),
    .bck_g     (bck_g),
    .bck_b     (bck_b),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] col(int i);
    case (i % 8)
      0: return 24'hFF0000;
      1: return 24'h00FF00;
      2: return 24'h0000FF;
      3: return 24'hFFFF00;
      4: return 24'hFF00FF;
      5: return 24'h00FFFF;
      6: return 24'hFFFFFF;
      default: return 24'h000000;
    endcase
  endfunction

  // Largest bar i whose start (e*i)/N_BARS does not exceed c.
  function automatic int bar_of(int c, int e);
    int best = 0;
    for (int k = 0; k < N_BARS; k++) begin
      if (c >= (e * k) / N_BARS) best = k;
    end
    return best;
  endfunction

  // White on the outermost active rows/columns when the border is built in.
  function automatic logic [23:0] bw(int x, int y, logic [23:0] c);
`ifdef PATTERN_BORDER_EN
    if (x == 0 || x == HACTIVE - 1 || y == 0 || y == VACTIVE - 1) return 24'hFFFFFF;
`endif
    return c;
  endfunction

  function automatic logic [23:0] model_px(int x, int y, int mode, int off, bit en);
    int p;
    if (!en || x < 0 || x >= HACTIVE || y < 0 || y >= VACTIVE) return 24'h000000;
    case (mode)
      0: return bw(x, y, col(bar_of(y, VACTIVE)));
      1: return bw(x, y, col(bar_of(x, HACTIVE)));
      2: return bw(x, y, col(((x / (1 << CELL_LOG2)) + (y / (1 << CELL_LOG2))) % N_BARS));
      default: begin
        p = (x + off) % HACTIVE;
        return bw(x, y, col(bar_of(p, HACTIVE)));
      end
    endcase
  endfunction

  task automatic check(string nm, logic [23:0] got, logic [23:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at t=%0t", nm, got, want, $time);
    end
  endtask

  // Drive one spot, advance the model, then compare after the clock edge.
  task automatic apply(int x, int y, bit en, int ms);
    bit sof;
    logic [23:0] exp_rgb;
    spot_x   = 11'(x);
    spot_y   = 11'(y);
    enable   = en;
    mode_sel = 2'(ms);
    sof = (x == 0 && y == 0);
    if (sof) begin
      m_mode = ms;
      if (m_mode == 3 && en) m_off = (m_off + SCROLL_STEP) % HACTIVE;
    end
    exp_rgb = model_px(x, y, m_mode, m_off, en);
    @(posedge clk);
    #1;
    check("model_rgb", {bck_r, bck_g, bck_b}, exp_rgb);
    check("model_tick", {23'd0, frame_tick}, {23'd0, sof});
  endtask

  task automatic lit(string nm, logic [23:0] want_rgb, bit want_tick);
    check(nm, {bck_r, bck_g, bck_b}, want_rgb);
    check({nm, "_tick"}, {23'd0, frame_tick}, {23'd0, want_tick});
  endtask

  initial begin
    int x0;
    reset_n  = 1'b0;
    spot_x   = 11'sd5;
    spot_y   = 11'sd5;
    enable   = 1'b1;
    mode_sel = 2'd1;
    @(posedge clk); #1;
    lit("reset_out", 24'h000000, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // HBARS after reset
    apply(10, 50, 1, 1);   lit("hb_y50", 24'hFF0000, 1'b0);
    apply(10, 150, 1, 1);  lit("hb_y150", 24'h00FF00, 1'b0);
    apply(10, 599, 1, 1);  lit("hb_y599", bw(10, 599, 24'h00FFFF), 1'b0);
    apply(10, 600, 1, 1);  lit("hb_y600", 24'h000000, 1'b0);

    // VBARS via SOF
    apply(0, 0, 1, 1);
    apply(133, 10, 1, 1);  lit("vb_x133", 24'h00FF00, 1'b0);
    apply(132, 10, 1, 1);  lit("vb_x132", 24'hFF0000, 1'b0);
    apply(450, 10, 1, 1);  lit("vb_x450", 24'hFFFF00, 1'b0);

    // Mid-frame mode change waits for the next SOF
    apply(0, 0, 1, 0);
    for (int y = 1; y < VACTIVE; y += 37) begin
      for (int k = 0; k < 4; k++) apply($urandom_range(0, HACTIVE - 1), y, 1, (y >= 300) ? 1 : 0);
    end
    apply(10, 350, 1, 1);  lit("hold_hbars", 24'hFFFF00, 1'b0);
    apply(0, 0, 1, 1);     lit("sof_vbars", bw(0, 0, 24'hFF0000), 1'b1);
    apply(500, 10, 1, 1);  lit("vb_after", 24'hFFFF00, 1'b0);

    // SCROLL: three SOFs give offset 6
    for (int i = 0; i < 3; i++) apply(0, 0, 1, 3);
    apply(130, 5, 1, 3);   lit("scr_off6", 24'h00FF00, 1'b0);
    for (int i = 0; i < 396; i++) apply(0, 0, 1, 3);
    apply(0, 5, 1, 3);     lit("scr_off798", bw(0, 5, 24'h00FFFF), 1'b0);
    apply(2, 5, 1, 3);     lit("scr_wrap_p", 24'hFF0000, 1'b0);
    apply(0, 0, 1, 3);     lit("scr_off0_sof", bw(0, 0, 24'hFF0000), 1'b1);
    apply(130, 5, 1, 3);   lit("scr_off0", 24'hFF0000, 1'b0);

    // CHECKER
    apply(0, 0, 1, 2);
    apply(70, 10, 1, 2);   lit("chk_70_10", 24'h00FF00, 1'b0);
    apply(70, 70, 1, 2);   lit("chk_70_70", 24'h0000FF, 1'b0);
    apply(-5, 10, 1, 2);   lit("chk_neg", 24'h000000, 1'b0);
    apply(70, 70, 0, 2);   lit("chk_dis", 24'h000000, 1'b0);

    // Randomised traffic, every cycle checked against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0)
        apply(0, 0, $urandom_range(0, 9) != 0, $urandom_range(0, 3));
      else
        apply(int'($urandom_range(0, HACTIVE + 39)) - 20, int'($urandom_range(0, VACTIVE + 39)) - 20,
              $urandom_range(0, 9) != 0, $urandom_range(0, 3));
    end

    // Asynchronous reset mid-frame in SCROLL
    apply(0, 0, 1, 3);
    x0 = (450 - m_off + HACTIVE) % HACTIVE;
    apply(x0, 5, 1, 3);    lit("pre_reset", 24'hFFFF00, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    lit("async_reset", 24'h000000, 1'b0);
    m_mode = 0;
    m_off  = 0;
    @(posedge clk); #1;
    lit("in_reset", 24'h000000, 1'b0);
    reset_n = 1'b1;
    apply(10, 150, 1, 3);  lit("post_hbars", 24'h00FF00, 1'b0);
    apply(0, 0, 1, 3);
    apply(798, 5, 1, 3);   lit("post_off2_a", 24'hFF0000, 1'b0);
    apply(131, 5, 1, 3);   lit("post_off2_b", 24'h00FF00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pattern_gen.md
Name: pattern_gen

Overview:
Parametrised test-pattern generator, the successor to the fixed six-band horizontal colour mire. It produces background RGB from the current spot position. It supports four run-time modes: horizontal bars, vertical bars, checkerboard, and horizontally scrolling bars. The block sits beside the sprite/background layers, feeds the compositor, and is used for bring-up and display calibration.

Parameters:
HACTIVE, 800, active pixels per line
VACTIVE, 600, active lines per frame
N_BARS, 6, number of bars in bar modes (1..8)
CELL_LOG2, 6, log2 of checkerboard cell size in pixels (64 px)
SCROLL_STEP, 2, pixels the scroll offset advances per frame (must be < HACTIVE)

Ports:
clk  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
spotX  in  11 signed  current pixel column
spotY  in  11 signed  current pixel line
enable  in  1  high = draw pattern; low = black output, scroll frozen
mode_sel  in  2  requested mode: 0 HBARS, 1 VBARS, 2 CHECKER, 3 SCROLL
bck_r, bck_g, bck_b  out  8 each  registered colour components
frame_tick  out  1  one-cycle pulse, one cycle after start-of-frame is seen

Behaviour:
- Reset (asynchronous, reset_n=0): bck_r/g/b=0, frame_tick=0, mode register=HBARS, scroll offset=0.
- Latency: exactly 1 clk. The colour for (spotX, spotY) presented in cycle n appears on the outputs in cycle n+1.
- Active region: 0<=spotX<HACTIVE and 0<=spotY<VACTIVE. Outside it, or when enable=0, the output is 0,0,0.
- Start-of-frame (SOF): spotX==0 and spotY==0 in the current cycle.
- frame_tick=1 in the cycle following SOF, regardless of enable.
- Mode register: loads mode_sel only at SOF. Changes to mode_sel mid-frame have no effect until the next SOF.
- Colour table, index i mod 8 -> components at 255 (others 0):
  - 0 R, 1 G, 2 B, 3 R+G, 4 R+B, 5 G+B, 6 R+G+B, 7 none.
- Bar index for coordinate c over extent E: the largest i in 0..N_BARS-1 with c >= (E*i)/N_BARS, integer truncation. For E=600, N=6 the boundaries are 100, 200, 300, 400, 500.
- HBARS: index from spotY over VACTIVE.
- VBARS: index from spotX over HACTIVE.
- CHECKER: index = ((spotX>>CELL_LOG2) + (spotY>>CELL_LOG2)) mod N_BARS.
- SCROLL: p = spotX + offset; if p >= HACTIVE then p -= HACTIVE. Index is the bar index of p over HACTIVE.
- Scroll offset:
  - At each SOF where mode register==SCROLL (value after load) and enable=1, offset += SCROLL_STEP, wrapping modulo HACTIVE (798+2 -> 0).
  - Offset holds in other modes and when enable=0.
  - Offset width is clog2(HACTIVE) bits, unsigned.
- Simultaneous SOF + mode change: the new mode applies to pixel (0,0) itself. A SCROLL offset increment applies from pixel (0,0) of that frame.
- All arithmetic in the pattern path is unsigned after the active-region check. Negative spot values never reach the index logic.

Optional Feature:
PATTERN_BORDER_EN
- Defined: a 1-pixel white border (255,255,255) is drawn at spotX==0, spotX==HACTIVE-1, spotY==0 and spotY==VACTIVE-1. It overrides every mode but is still blanked when enable=0.
- Not defined: no border logic; pattern pixels are drawn at the edges.

Decomposition:
- pattern_pkg holds:
  - typedef enum pattern_mode_t {HBARS, VBARS, CHECKER, SCROLL}
  - rgb_t packed struct of three 8-bit fields
  - constant colour table (8 entries of 3-bit codes) and a function mapping a code to rgb_t
- Sub-module bar_index, parametrised by EXTENT and N_BARS. It is a combinational compare ladder returning a 3-bit index. It is instantiated twice: once for Y, and once shared for X/p.

Test Plan:
1. Reset, mode 0, enable=1: spot (10,50) -> next cycle 255,0,0; (10,150) -> 0,255,0; (10,599) -> 0,255,255; (10,600) -> 0,0,0.
2. SOF with mode_sel=1: spot (133,10) -> 0,255,0 (boundary 133); (132,10) -> 255,0,0; (450,10) -> 255,255,0.
3. Mode 0 frame, mode_sel driven to 1 at spotY=300: output stays HBARS colours until (0,0). From (0,0) onward, VBARS colours; frame_tick pulses the cycle after (0,0).
4. SCROLL mode, SCROLL_STEP=2: after SOFs #1..#3 offset=6. Spot (130,5) -> p=136 -> 0,255,0. Preload 399 SOFs -> offset 798, next SOF -> offset 0.
5. CHECKER: (70,10) -> 0,255,0; (70,70) -> 0,0,255; spot (-5,10) -> 0,0,0; enable=0 at (70,70) -> 0,0,0.
6. reset_n asserted mid-frame in SCROLL while output=255,255,0: outputs go 0 with no clock edge; after release, mode=HBARS and offset=0.
